// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter. Pipeline writes own the port; long-latency
// results wait in an in-order queue and drain into idle port cycles.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [ADDR_W-1:0]      pipe_waddr,
  input  logic [DATA_W-1:0]      pipe_wdata,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [ADDR_W-1:0]      lu_waddr,
  input  logic [DATA_W-1:0]      lu_wdata,
  output logic                   we,
  output logic [ADDR_W-1:0]      waddr,
  output logic [DATA_W-1:0]      wdata,
  output logic [(1<<ADDR_W)-1:0] pend_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  q_valid;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;

  logic full, empty, pipe_hit, push, head_valid, pop;

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign lu_ready   = rst & ~full;
  assign pipe_hit   = pipe_we && (pipe_waddr != '0);
  assign push       = lu_valid && lu_ready && (lu_waddr != '0);
  assign head_valid = !empty && q_valid[rd_ptr];
  // A squashed head retires even while the pipeline holds the port.
  assign pop        = !empty && (!q_valid[rd_ptr] || !pipe_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      q_valid <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (pipe_hit) begin
        we    <= 1'b1;
        waddr <= pipe_waddr;
        wdata <= pipe_wdata;
      end else if (head_valid) begin
        we    <= 1'b1;
        waddr <= q_addr[rd_ptr];
        wdata <= q_data[rd_ptr];
      end else begin
        we <= 1'b0;
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (pipe_hit && (q_addr[i] == pipe_waddr)) q_valid[i] <= 1'b0;
      end

      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end

      if (push) begin
        q_valid[wr_ptr] <= !(pipe_hit && (pipe_waddr == lu_waddr));
        q_addr[wr_ptr]  <= lu_waddr;
        q_data[wr_ptr]  <= lu_wdata;
        wr_ptr          <= wr_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) pend_mask[q_addr[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected port writes are queued as
// stimulus is driven and matched in order against every observed write.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_waddr;
  logic [DW-1:0] lu_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [31:0]   pend_mask;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample just after the edge, match any write in order.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    check("we_known", 64'($isunknown(we)), 64'd0);
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 64'(we), 64'd0);
      end else begin
        e = sb.pop_front();
        check("waddr", 64'(waddr), 64'(e.a));
        check("wdata", 64'(wdata), 64'(e.d));
      end
    end
  endtask

  task automatic drive_pipe(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pipe_we = v; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lu_valid = v; lu_waddr = a; lu_wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    drive_pipe(1'b1, 5'd4, 32'h44);
    drive_lu(1'b1, 5'd6, 32'h66);

    // Reset held with active requests
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_we", 64'(we), 64'd0);
      check("rst_lu_ready", 64'(lu_ready), 64'd0);
      check("rst_pend_mask", 64'(pend_mask), 64'd0);
    end
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    check("release_lu_ready", 64'(lu_ready), 64'd1);
    check("release_waddr", 64'(waddr), 64'd0);
    check("release_wdata", 64'(wdata), 64'd0);

    // Pipeline path: one-cycle latency; register 0 ignored
    drive_pipe(1'b1, 5'd5, 32'h1234);
    expect_wr(5'd5, 32'h1234);
    step();
    check("pipe_we", 64'(we), 64'd1);
    drive_pipe(1'b1, 5'd0, 32'hDEAD);
    step();
    check("pipe_r0_we", 64'(we), 64'd0);
    drive_pipe(1'b0, 5'd0, 32'h0);

    // Queue drain: 7 then 8, first write two cycles after first accept
    drive_lu(1'b1, 5'd7, 32'hA);
    expect_wr(5'd7, 32'hA);
    step();
    check("drain_we0", 64'(we), 64'd0);
    check("drain_mask7", 64'(pend_mask), 64'(1) << 7);
    drive_lu(1'b1, 5'd8, 32'hB);
    expect_wr(5'd8, 32'hB);
    step();
    check("drain_we1", 64'(we), 64'd1);
    check("drain_mask8", 64'(pend_mask), 64'(1) << 8);
    drive_lu(1'b0, 5'd0, 32'h0);
    step();
    check("drain_we2", 64'(we), 64'd1);
    check("drain_mask0", 64'(pend_mask), 64'd0);
    step();
    check("drain_idle", 64'(we), 64'd0);

    // Contention: pipeline owns the port, queue fills at two
    drive_pipe(1'b1, 5'd3, 32'h33);
    drive_lu(1'b1, 5'd9, 32'h9);
    expect_wr(5'd3, 32'h33);
    check("cont_ready0", 64'(lu_ready), 64'd1);
    step();
    drive_lu(1'b1, 5'd10, 32'h10);
    expect_wr(5'd3, 32'h33);
    check("cont_ready1", 64'(lu_ready), 64'd1);
    step();
    drive_lu(1'b1, 5'd11, 32'h11);
    expect_wr(5'd3, 32'h33);
    check("cont_ready_full", 64'(lu_ready), 64'd0);
    check("cont_mask", 64'(pend_mask), (64'(1) << 9) | (64'(1) << 10));
    step();
    expect_wr(5'd3, 32'h33);
    check("cont_still_full", 64'(lu_ready), 64'd0);
    step();
    drive_pipe(1'b0, 5'd0, 32'h0);
    expect_wr(5'd9, 32'h9);
    expect_wr(5'd10, 32'h10);
    expect_wr(5'd11, 32'h11);
    step();
    check("cont_we9", 64'(we), 64'd1);
    check("cont_ready_after_pop", 64'(lu_ready), 64'd1);
    step();
    drive_lu(1'b0, 5'd0, 32'h0);
    check("cont_we10", 64'(we), 64'd1);
    step();
    check("cont_we11", 64'(we), 64'd1);
    step();
    check("cont_idle", 64'(we), 64'd0);

    // WAW squash, including a same-cycle accept to the same register
    drive_lu(1'b1, 5'd12, 32'hC);
    step();
    drive_lu(1'b0, 5'd0, 32'h0);
    check("waw_mask_set", 64'(pend_mask), 64'(1) << 12);
    drive_pipe(1'b1, 5'd12, 32'hD);
    drive_lu(1'b1, 5'd12, 32'hE);
    expect_wr(5'd12, 32'hD);
    step();
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    check("waw_mask_clear", 64'(pend_mask), 64'd0);
    check("waw_full", 64'(lu_ready), 64'd0);
    step();
    check("waw_pop1_no_we", 64'(we), 64'd0);
    check("waw_pop1_ready", 64'(lu_ready), 64'd1);
    drive_lu(1'b1, 5'd13, 32'h13);
    expect_wr(5'd13, 32'h13);
    step();
    drive_lu(1'b0, 5'd0, 32'h0);
    check("waw_pop2_no_we", 64'(we), 64'd0);
    check("waw_mask13", 64'(pend_mask), 64'(1) << 13);
    step();
    check("waw_we13", 64'(we), 64'd1);

    // Register 0 results are accepted but never queued
    for (int i = 0; i < 3; i++) begin
      drive_lu(1'b1, 5'd0, 32'hFFFF);
      check("r0_ready", 64'(lu_ready), 64'd1);
      step();
      check("r0_mask", 64'(pend_mask), 64'd0);
    end
    drive_lu(1'b0, 5'd0, 32'h0);
    step();
    check("r0_no_we", 64'(we), 64'd0);
    check("r0_ready_after", 64'(lu_ready), 64'd1);

    // Mid-operation reset drops queued results
    drive_lu(1'b1, 5'd14, 32'h14);
    step();
    drive_lu(1'b0, 5'd0, 32'h0);
    check("mid_mask14", 64'(pend_mask), 64'(1) << 14);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_mask", 64'(pend_mask), 64'd0);
    check("mid_rst_ready", 64'(lu_ready), 64'd0);
    check("mid_rst_we", 64'(we), 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("mid_no_we", 64'(we), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
